// File: rtl/bcd_countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// The FSM state encodings are visible on bState, so their values must not change.
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Illegal BCD nibbles (A..F) saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counter: it loads a clamped value or takes one borrow.
// It produces a borrow-out when it wraps from 0 to 9.
module bcd_digit_down
  import bcd_countdown_pkg::*;
(
  input  logic       BrdClk,
  input  logic       aReset,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_borrow_out,
  output logic       o_zero
);

  logic [3:0] r_digit;
  logic       w_zero;

  assign w_zero = (r_digit == 4'd0);

  always_ff @(posedge BrdClk) begin
    if (aReset) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_value);
    end else if (i_borrow_in) begin
      r_digit <= w_zero ? BCD_MAX : (r_digit - 4'd1);
    end
  end

  assign o_digit      = r_digit;
  assign o_zero       = w_zero;
  assign o_borrow_out = i_borrow_in & w_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Presettable multi-digit BCD countdown timer with synchronized tick/start/stop inputs.
// The timer emits a one-cycle expiry pulse and can optionally reload itself on expiry.
module bcd_countdown_timer
  import bcd_countdown_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
)
(
  input  logic                BrdClk,
  input  logic                aReset,
  input  logic                aTick,
  input  logic                aStart,
  input  logic                aStop,
  input  logic                bLoad,
  input  logic [4*DIGITS-1:0] bLoadValue,
  output logic [4*DIGITS-1:0] bCount,
  output logic [1:0]          bState,
  output logic                bRunning,
  output logic                bExpired
);

  localparam int W = 4 * DIGITS;
  localparam int EV_TICK  = 0;
  localparam int EV_START = 1;
  localparam int EV_STOP  = 2;
  localparam logic [W-1:0] COUNT_ONE = W'(1);

  logic [2:0] w_async_in;
  logic [2:0] w_pulse;

  assign w_async_in = {aStop, aStart, aTick};

  // Two-flop synchronizer followed by a previous-value flop, giving a rising-edge pulse.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge BrdClk) begin
      if (aReset) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
        r_s3 <= 1'b0;
      end else begin
        r_s1 <= w_async_in[gi];
        r_s2 <= r_s1;
        r_s3 <= r_s2;
      end
    end
    assign w_pulse[gi] = r_s2 & ~r_s3;
  end

  state_t       r_state, w_state_next;
  logic [W-1:0] r_preset;
  logic         r_running, r_expired;
  logic [W-1:0] w_load_clamped;
  logic [W-1:0] w_dig_value;
  logic         w_dig_load, w_dec, w_expired_next, w_preset_load;
  logic [DIGITS-1:0] w_zero;
  logic [DIGITS:0]   w_borrow;
  logic         w_count_zero, w_count_one, w_preset_zero;

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[4*i +: 4] = bcd_clamp(bLoadValue[4*i +: 4]);
    end
  end

  assign w_count_zero  = &w_zero;
  assign w_count_one   = (bCount == COUNT_ONE);
  assign w_preset_zero = (r_preset == '0);

  // Only one event acts per cycle: load, then stop, then start, then tick.
  always_comb begin
    w_state_next   = r_state;
    w_dig_load     = 1'b0;
    w_dig_value    = w_load_clamped;
    w_dec          = 1'b0;
    w_expired_next = 1'b0;
    w_preset_load  = 1'b0;
    if (bLoad) begin
      w_dig_load    = 1'b1;
      w_preset_load = 1'b1;
      w_state_next  = ST_IDLE;
    end else if (w_pulse[EV_STOP]) begin
      case (r_state)
        ST_RUN:              w_state_next = ST_PAUSED;
        ST_PAUSED, ST_DONE:  w_state_next = ST_IDLE;
        default:             w_state_next = r_state;
      endcase
    end else if (w_pulse[EV_START]) begin
      case (r_state)
        ST_IDLE:   w_state_next = w_count_zero ? ST_DONE : ST_RUN;
        ST_PAUSED: w_state_next = ST_RUN;
        ST_DONE: begin
          if (!w_preset_zero) begin
            w_dig_load   = 1'b1;
            w_dig_value  = r_preset;
            w_state_next = ST_RUN;
          end
        end
        default:   w_state_next = r_state;
      endcase
    end else if (w_pulse[EV_TICK] && (r_state == ST_RUN) && !w_count_zero) begin
      w_expired_next = w_count_one;
      if (w_count_one && AUTO_RELOAD && !w_preset_zero) begin
        w_dig_load  = 1'b1;
        w_dig_value = r_preset;
      end else begin
        w_dec = 1'b1;
        if (w_count_one) w_state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge BrdClk) begin
    if (aReset) begin
      r_state   <= ST_IDLE;
      r_preset  <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
      r_expired <= w_expired_next;
      if (w_preset_load) r_preset <= w_load_clamped;
    end
  end

  assign w_borrow[0] = w_dec;

  for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit
    bcd_digit_down u_digit (
      .BrdClk       (BrdClk),
      .aReset       (aReset),
      .i_load       (w_dig_load),
      .i_load_value (w_dig_value[4*gd +: 4]),
      .i_borrow_in  (w_borrow[gd]),
      .o_digit      (bCount[4*gd +: 4]),
      .o_borrow_out (w_borrow[gd+1]),
      .o_zero       (w_zero[gd])
    );
  end

  // A borrow out of the top digit would mean the count wrapped below zero.
  a_no_underflow: assert property (@(posedge BrdClk) disable iff (aReset) !w_borrow[DIGITS]);

  assign bState   = r_state;
  assign bRunning = r_running;
  assign bExpired = r_expired;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance without auto-reload and one with it.
// Inputs are driven and outputs are sampled on the falling edge of BrdClk.
module tb_bcd_countdown_timer;

  logic        BrdClk = 1'b0;
  logic        aReset, aTick, aStart, aStop, bLoad;
  logic [15:0] bLoadValue;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  st_a, st_b;
  logic        run_a, run_b, exp_a, exp_b;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  localparam logic [2:0] M_TICK  = 3'b001;
  localparam logic [2:0] M_START = 3'b010;
  localparam logic [2:0] M_STOP  = 3'b100;

  always #5 BrdClk = ~BrdClk;

  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u_dut_a (
    .BrdClk(BrdClk), .aReset(aReset), .aTick(aTick), .aStart(aStart), .aStop(aStop),
    .bLoad(bLoad), .bLoadValue(bLoadValue), .bCount(cnt_a), .bState(st_a),
    .bRunning(run_a), .bExpired(exp_a)
  );

  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u_dut_b (
    .BrdClk(BrdClk), .aReset(aReset), .aTick(aTick), .aStart(aStart), .aStop(aStop),
    .bLoad(bLoad), .bLoadValue(bLoadValue), .bCount(cnt_b), .bState(st_b),
    .bRunning(run_b), .bExpired(exp_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the selected async inputs high long enough to be synchronized, then release.
  // This returns on the falling edge just after the event took effect.
  task automatic pulse_async(input logic [2:0] mask);
    {aStop, aStart, aTick} = mask;
    repeat (2) @(negedge BrdClk);
    {aStop, aStart, aTick} = 3'b000;
    @(negedge BrdClk);
  endtask

  task automatic do_load(input logic [15:0] v);
    bLoad      = 1'b1;
    bLoadValue = v;
    @(negedge BrdClk);
    bLoad      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_pulse6;
    aReset = 1'b1; aTick = 1'b0; aStart = 1'b0; aStop = 1'b0;
    bLoad = 1'b0; bLoadValue = 16'h0000;
    repeat (3) @(negedge BrdClk);
    check_eq("rst_count", cnt_a, 16'h0000);
    check_eq("rst_state", 16'(st_a), 16'h0000);
    check_eq("rst_running", 16'(run_a), 16'h0000);
    check_eq("rst_expired", 16'(exp_a), 16'h0000);
    aReset = 1'b0;
    @(negedge BrdClk);

    // Test 1: count down from 3 to expiry.
    do_load(16'h0003);
    check_eq("t1_load", cnt_a, 16'h0003);
    check_eq("t1_load_state", 16'(st_a), 16'h0000);
    pulse_async(M_START);
    check_eq("t1_run_state", 16'(st_a), 16'h0001);
    check_eq("t1_running", 16'(run_a), 16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      pulse_async(M_TICK);
      check_eq("t1_tick_count", cnt_a, exp_q.pop_front());
      if (i < 2) check_eq("t1_no_expire", 16'(exp_a), 16'h0000);
    end
    check_eq("t1_expired_hi", 16'(exp_a), 16'h0001);
    check_eq("t1_done_state", 16'(st_a), 16'h0003);
    check_eq("t1_not_running", 16'(run_a), 16'h0000);
    @(negedge BrdClk);
    check_eq("t1_expired_lo", 16'(exp_a), 16'h0000);
    pulse_async(M_TICK);
    check_eq("t1_tick_at_zero", cnt_a, 16'h0000);
    check_eq("t1_stay_done", 16'(st_a), 16'h0003);

    // Test 2: borrow ripples across digits.
    do_load(16'h0100);
    pulse_async(M_START);
    pulse_async(M_TICK);
    check_eq("t2_borrow_2dig", cnt_a, 16'h0099);
    do_load(16'h1000);
    pulse_async(M_START);
    pulse_async(M_TICK);
    check_eq("t2_borrow_3dig", cnt_a, 16'h0999);

    // Test 3: clamping, and starting from zero.
    do_load(16'h00AF);
    check_eq("t3_clamp", cnt_a, 16'h0099);
    do_load(16'h0000);
    pulse_async(M_START);
    check_eq("t3_zero_done", 16'(st_a), 16'h0003);
    check_eq("t3_zero_no_exp", 16'(exp_a), 16'h0000);
    @(negedge BrdClk);
    check_eq("t3_zero_no_exp2", 16'(exp_a), 16'h0000);

    // Test 4: pause and resume.
    do_load(16'h0050);
    pulse_async(M_START);
    pulse_async(M_STOP);
    check_eq("t4_paused", 16'(st_a), 16'h0002);
    for (int i = 0; i < 5; i++) pulse_async(M_TICK);
    check_eq("t4_paused_hold", cnt_a, 16'h0050);
    pulse_async(M_START);
    check_eq("t4_resume", 16'(st_a), 16'h0001);
    pulse_async(M_TICK);
    check_eq("t4_tick", cnt_a, 16'h0049);
    pulse_async(M_STOP);
    pulse_async(M_STOP);
    check_eq("t4_idle", 16'(st_a), 16'h0000);
    check_eq("t4_idle_count", cnt_a, 16'h0049);

    // Test 5: a stop arriving with a tick wins; a load arriving with a start wins.
    do_load(16'h0020);
    pulse_async(M_START);
    pulse_async(M_STOP | M_TICK);
    check_eq("t5_stop_tick_state", 16'(st_a), 16'h0002);
    check_eq("t5_stop_tick_count", cnt_a, 16'h0020);
    aStart = 1'b1;
    repeat (2) @(negedge BrdClk);
    aStart = 1'b0;
    do_load(16'h0042);
    check_eq("t5_load_start_state", 16'(st_a), 16'h0000);
    check_eq("t5_load_start_count", cnt_a, 16'h0042);
    repeat (3) @(negedge BrdClk);
    check_eq("t5_start_discarded", 16'(st_a), 16'h0000);

    // Test 6: auto-reload instance, then a reset during the run.
    do_load(16'h0002);
    pulse_async(M_START);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0001);
    exp_pulse6 = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      pulse_async(M_TICK);
      check_eq("t6_count", cnt_b, exp_q.pop_front());
      check_eq("t6_expired", 16'(exp_b), 16'(exp_pulse6[i]));
      check_eq("t6_state_run", 16'(st_b), 16'h0001);
    end
    aTick = 1'b1;
    @(negedge BrdClk);
    aReset = 1'b1;
    @(negedge BrdClk);
    check_eq("t6_rst_count", cnt_b, 16'h0000);
    check_eq("t6_rst_state", 16'(st_b), 16'h0000);
    check_eq("t6_rst_expired", 16'(exp_b), 16'h0000);
    check_eq("t6_rst_running", 16'(run_b), 16'h0000);
    check_eq("t6_rst_count_a", cnt_a, 16'h0000);
    aTick = 1'b0;
    @(negedge BrdClk);
    aReset = 1'b0;
    repeat (4) @(negedge BrdClk);
    check_eq("t6_post_rst_state", 16'(st_b), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Presettable, multi-digit BCD down-counter timer; the decrementing counterpart of the team's up-counter blocks.
- Borrow ripples down the digit chain where the up-counter ripples a carry.
- Sits between asynchronous board inputs (tick, start, stop) and BrdClk-domain control logic.
- Raises a one-cycle expiry pulse when the count reaches zero; optionally auto-reloads.

Parameters:
- DIGITS, 4, number of BCD digits (legal 1..8); count width = 4*DIGITS.
- AUTO_RELOAD, 0, 1 = on expiry reload the preset value and stay running; 0 = stop in DONE.

Ports:
- BrdClk  in  1  board clock.
- aReset  in  1  reset, synchronous, active-high; clock BrdClk.
- aTick  in  1  asynchronous decrement request; each synchronized rising edge = one decrement.
- aStart  in  1  asynchronous start/resume request; acts on its synchronized rising edge.
- aStop  in  1  asynchronous stop/pause request; acts on its synchronized rising edge.
- bLoad  in  1  BrdClk-synchronous load strobe.
- bLoadValue  in  4*DIGITS  BCD preset; digit 0 is in bits [3:0].
- bCount  out  4*DIGITS  current BCD count.
- bState  out  2  FSM state: IDLE=00, RUN=01, PAUSED=10, DONE=11.
- bRunning  out  1  high while in RUN.
- bExpired  out  1  one-cycle pulse when the count reaches 0 from RUN.

Behaviour:
- Reset: bCount=0, preset register=0, bState=IDLE, bRunning=0, bExpired=0; all synchronizer and edge flops cleared.
- Synchronizers:
  - Each a* input passes through a 2-flop synchronizer plus a previous-value flop; edge pulse = s2 & ~s3.
  - An input first sampled high at edge k produces a pulse in the cycle after edge k+1; it takes effect at edge k+2.
  - An input held high produces exactly one pulse; the next pulse needs a low level seen by the synchronizer.
- Load:
  - bLoad in any state: bCount <= bLoadValue, preset register <= bLoadValue, state -> IDLE, bExpired=0.
  - Any nibble >9 is clamped to 9 in both bCount and the preset register.
- Priority within one cycle: bLoad > stop pulse > start pulse > tick pulse. Lower-priority events that cycle are discarded, not queued.
- IDLE: holds the count; ticks are ignored. A start pulse goes to RUN if bCount != 0, else to DONE with no bExpired pulse.
- RUN:
  - A tick pulse decrements bCount by 1 in BCD: digit 0 borrows and becomes 9; borrow ripples toward the MSD.
  - A tick when bCount == 1 sets bCount = 0 and pulses bExpired in the following cycle.
    - AUTO_RELOAD=0: state -> DONE.
    - AUTO_RELOAD=1: bCount <= preset in the same edge instead of 0; state stays RUN; bExpired still pulses.
    - AUTO_RELOAD=1 with preset == 0: go to DONE.
  - A stop pulse goes to PAUSED; the count is held.
- PAUSED: count held; ticks ignored. A start pulse goes to RUN. A stop pulse goes to IDLE with the count unchanged.
- DONE: bCount == 0, ticks ignored. A start pulse reloads the preset and goes to RUN (preset == 0: stay in DONE). A stop pulse goes to IDLE.
- bCount never wraps below 0; no decrement from 0 is ever applied.
- bRunning = (bState == RUN), registered together with the state.
- Reset asserted mid-count: state and count are cleared at that edge; a pending synchronizer edge is dropped.

Decomposition:
- Package bcd_countdown_pkg:
  - state enum (IDLE/RUN/PAUSED/DONE) with the fixed 2-bit encodings above;
  - BCD_MAX = 4'd9;
  - a BCD clamp function.
- Sub-module bcd_digit_down:
  - one digit register with load, clamp, borrow-in and borrow-out, and a zero flag;
  - instantiated DIGITS times by a generate loop.
- The synchronizer + edge detector is a local generate block, not a separate module.

Test Plan:
1. Reset, bLoad with 0x0003, start, then 3 tick edges -> bCount steps 0x0002, 0x0001, 0x0000; bExpired pulses for exactly 1 cycle; bState=DONE; a 4th tick leaves bCount at 0x0000.
2. Load 0x0100, start, one tick -> bCount=0x0099 (borrow across digits). Load 0x1000, one tick -> 0x0999.
3. Load 0x00AF -> bCount=0x0099 (clamping). Load 0x0000 then start -> DONE immediately, no bExpired pulse.
4. RUN at 0x0050: stop -> PAUSED; 5 ticks -> bCount stays 0x0050; start -> RUN; tick -> 0x0049; stop twice -> IDLE with 0x0049.
5. Same cycle stop pulse + tick pulse in RUN at 0x0020 -> PAUSED, bCount=0x0020. bLoad together with start -> IDLE with the new value loaded.
6. AUTO_RELOAD=1, preset 0x0002, 5 ticks -> 1, 2(reload, bExpired), 1, 2(reload, bExpired), 1. Assert aReset mid-run -> bCount=0, IDLE, bExpired=0.
